// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader
// Description : Sequential debug reader for a 32x32 register file. On START
//               it walks the second read port through every register index,
//               captures each word and streams it out with its index over a
//               valid/ready handshake. It never writes the register file.
// Config      : REG_DUMP_SKIP_X0_EN - when defined, the walk starts at index 1
//               and x0 is never emitted. When undefined, the walk starts at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader #(
   parameter int NREGS  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] RD_ADDR,
   input  logic [DATA_W-1:0] RD_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic [ADDR_W-1:0] OUT_IDX,
   output logic              OUT_LAST
);

   // First index of the walk: x0 is optionally skipped.
`ifdef REG_DUMP_SKIP_X0_EN
   localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(0);
`endif

   // Final index of the walk; the address never wraps past it.
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREGS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [ADDR_W-1:0] w_rd_addr_nxt;
   logic [DATA_W-1:0] r_out_data;
   logic [DATA_W-1:0] w_out_data_nxt;
   logic [ADDR_W-1:0] r_out_idx;
   logic [ADDR_W-1:0] w_out_idx_nxt;
   logic              r_out_last;
   logic              w_out_last_nxt;
   logic              r_out_valid;
   logic              w_out_valid_nxt;

   // State and datapath registers; reset aborts any dump in progress.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_rd_addr   <= '0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rd_addr   <= w_rd_addr_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_idx   <= w_out_idx_nxt;
         r_out_last  <= w_out_last_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Next-state and next-datapath logic: hold everything unless a state acts.
   always_comb begin
      w_state_nxt     = r_state;
      w_rd_addr_nxt   = r_rd_addr;
      w_out_data_nxt  = r_out_data;
      w_out_idx_nxt   = r_out_idx;
      w_out_last_nxt  = r_out_last;
      w_out_valid_nxt = r_out_valid;

      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_rd_addr_nxt = c_FIRST;
               w_state_nxt   = S_LOAD;
            end
         end

         S_LOAD: begin
            // RD_DATA is combinational for the registered RD_ADDR, so the
            // word captured here reflects register contents this cycle.
            w_out_data_nxt  = RD_DATA;
            w_out_idx_nxt   = r_rd_addr;
            w_out_last_nxt  = (r_rd_addr == c_LAST);
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_SEND;
         end

         S_SEND: begin
            // Outputs stay frozen until the consumer takes the word.
            if (r_out_valid && OUT_READY) begin
               w_out_valid_nxt = 1'b0;
               if (r_out_last) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                  w_state_nxt   = S_LOAD;
               end
            end
         end

         S_FIN: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign BUSY      = (r_state != S_IDLE);
   assign DONE      = (r_state == S_FIN);
   assign RD_ADDR   = r_rd_addr;
   assign OUT_VALID = r_out_valid;
   assign OUT_DATA  = r_out_data;
   assign OUT_IDX   = r_out_idx;
   assign OUT_LAST  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_dump_reader
// Description : Self-checking bench for reg_dump_reader. A behavioural
//               register file feeds RD_DATA; each dump is compared against
//               the expected word list derived from register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

`ifdef REG_DUMP_SKIP_X0_EN
   localparam int FIRST = 1;
`else
   localparam int FIRST = 0;
`endif
   localparam int W = 32 - FIRST;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        START;
   logic        BUSY;
   logic        DONE;
   logic [4:0]  RD_ADDR;
   logic [31:0] RD_DATA;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] OUT_DATA;
   logic [4:0]  OUT_IDX;
   logic        OUT_LAST;

   logic [31:0] regs [0:31];
   int checks   = 0;
   int failures = 0;

   // Register file read port: x0 is hard-wired to zero.
   assign RD_DATA = (RD_ADDR == 5'd0) ? 32'h0 : regs[RD_ADDR];

   always #5 CLK = ~CLK;

   reg_dump_reader #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .BUSY(BUSY), .DONE(DONE),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX),
      .OUT_LAST(OUT_LAST)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  BUSY, 0);
      check({tag, "_done"},  DONE, 0);
      check({tag, "_valid"}, OUT_VALID, 0);
      check({tag, "_last"},  OUT_LAST, 0);
      check({tag, "_addr"},  RD_ADDR, 0);
      check({tag, "_data"},  OUT_DATA, 0);
      check({tag, "_idx"},   OUT_IDX, 0);
   endtask

   // mode: 0 ready always, 1 random 1-in-3, 2 ready every third cycle.
   // restart_idx / write_idx / abort_idx: -1 disables the event.
   task automatic run_dump(input int mode, input int restart_idx, input int write_idx,
                           input int abort_idx);
      logic [31:0] exp_arr [0:31];
      int nxt = FIRST, words = 0, dones = 0, cyc = 0, done_cyc = -1;
      bit hold = 0, restarted = 0, restart_pending = 0, wrote = 0, rdy;
      logic [31:0] hd;
      logic [4:0]  hi;
      logic        hl;

      for (int i = 0; i < 32; i++) exp_arr[i] = (i == 0) ? 32'h0 : regs[i];

      @(negedge CLK); START = 1'b1;
      @(negedge CLK); START = 1'b0; cyc = 1;
      check("busy_after_start", BUSY, 1);

      while (cyc < 3000) begin
         if (restart_pending) begin START = 1'b0; restart_pending = 0; end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check("done_one_cycle", DONE, 0);
            check("idle_after_done", BUSY, 0);
            break;
         end
         if (hold) begin
            check("hold_valid", OUT_VALID, 1);
            check("hold_data",  OUT_DATA, hd);
            check("hold_idx",   OUT_IDX, hi);
            check("hold_last",  OUT_LAST, hl);
         end
         if (DONE) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
         if (OUT_VALID) begin
            if (abort_idx >= 0 && int'(OUT_IDX) == abort_idx) begin
               OUT_READY = 1'b0;
               RESET_N = 1'b0;
               #1;
               check_all_zero("abort");
               repeat (2) begin
                  @(negedge CLK);
                  check("abort_no_done", DONE, 0);
               end
               RESET_N = 1'b1;
               repeat (2) begin
                  @(negedge CLK);
                  check("abort_stays_idle", BUSY, 0);
                  check("abort_no_done2", DONE, 0);
               end
               return;
            end
            if (write_idx >= 0 && !wrote && int'(OUT_IDX) == write_idx) begin
               regs[20] = 32'hDEADBEEF;
               exp_arr[20] = 32'hDEADBEEF;
               wrote = 1;
            end
            if (restart_idx >= 0 && !restarted && int'(OUT_IDX) == restart_idx) begin
               START = 1'b1;
               restart_pending = 1;
               restarted = 1;
            end
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) == 0);
            default: rdy = (cyc % 3 == 0);
         endcase
         OUT_READY = rdy;
         if (OUT_VALID && rdy) begin
            check("word_data", OUT_DATA, (nxt < 32) ? exp_arr[nxt] : 32'hx);
            check("word_idx",  OUT_IDX, nxt);
            check("word_last", OUT_LAST, (nxt == 31));
            nxt++; words++; hold = 0;
         end else if (OUT_VALID) begin
            hold = 1; hd = OUT_DATA; hi = OUT_IDX; hl = OUT_LAST;
         end else begin
            hold = 0;
         end
         @(negedge CLK); cyc++;
      end
      OUT_READY = 1'b0;
      check("dump_finished_in_budget", (done_cyc >= 0), 1);
      check("word_count", words, W);
      check("done_pulses", dones, 1);
      if (mode == 0 && restart_idx < 0) check("done_latency", done_cyc, 2 * W + 1);
      check("rd_addr_holds_last", RD_ADDR, 31);
   endtask

   initial begin
      RESET_N = 1'b1; START = 1'b0; OUT_READY = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      #2 RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      check_all_zero("reset");
      RESET_N = 1'b1;
      @(negedge CLK);
      check("idle_after_reset", BUSY, 0);

      // Full dump with the consumer always ready; checks DONE latency.
      run_dump(0, -1, -1, -1);
      // Deterministic backpressure, ready one cycle in three.
      run_dump(2, -1, -1, -1);
      // START pulsed again mid-dump must be ignored.
      run_dump(0, 5, -1, -1);
      // Reset asserted at idx 12, then a fresh complete dump.
      run_dump(0, -1, -1, 12);
      check_all_zero("post_abort");
      run_dump(0, -1, -1, -1);
      // Core write to x20 while the dump is at idx 10, random backpressure.
      run_dump(1, -1, 10, -1);
      // Random register contents and random backpressure.
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      run_dump(1, -1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
